// File: rtl/z_writeback_seq_pkg.sv
// Shared datapath definitions for the HI/LO writeback sequencers.
// The future divider writeback reuses the same protocol and state encoding.
package z_writeback_seq_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND_LO = 2'd1,
      ST_SEND_HI = 2'd2
   } state_t;

endpackage

// File: rtl/z_writeback_seq_if.sv
// Product-in / bus-out handshake bundle for the Z writeback sequencer.
interface z_writeback_seq_if #(
   parameter int DATA_W = z_writeback_seq_pkg::DATA_W
) ();

   logic                  prod_valid;
   logic                  prod_ready;
   logic [2*DATA_W-1:0]   prod_in;
   logic                  flush;
   logic [DATA_W-1:0]     bus_out;
   logic                  bus_valid;
   logic                  bus_ready;
   logic                  lo_en;
   logic                  hi_en;
   logic                  busy;
   logic                  fits32;
   logic                  done;

   modport slave (
      input  prod_valid, prod_in, flush, bus_ready,
      output prod_ready, bus_out, bus_valid, lo_en, hi_en, busy, fits32, done
   );

   modport master (
      output prod_valid, prod_in, flush, bus_ready,
      input  prod_ready, bus_out, bus_valid, lo_en, hi_en, busy, fits32, done
   );

endinterface

// File: rtl/z_writeback_seq_z_reg64.sv
// Product holding register (Zhi:Zlo) with load enable and asynchronous clear.
module z_reg64 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Z storage: cleared asynchronously, loaded only on capture
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/z_writeback_seq.sv
// Captures a 64-bit product into Z and writes it out as LO then HI words,
// reporting whether the product fits a signed 32-bit value.
module z_writeback_seq #(
   parameter int DATA_W = z_writeback_seq_pkg::DATA_W
) (
   input  logic               clk,
   input  logic               clr,
   z_writeback_seq_if.slave   sif
);

   import z_writeback_seq_pkg::*;

   state_t                r_state;
   state_t                w_next;
   logic                  r_done;
   logic                  w_done_next;
   logic                  w_capture;
   logic                  w_prod_ready;
   logic                  w_bus_valid;
   logic [DATA_W-1:0]     w_bus_out;
   logic                  w_lo_en;
   logic                  w_hi_en;
   logic [2*DATA_W-1:0]   w_z;
   logic [DATA_W-1:0]     w_zlo;
   logic [DATA_W-1:0]     w_zhi;

   assign w_zlo = w_z[DATA_W-1:0];
   assign w_zhi = w_z[2*DATA_W-1:DATA_W];

   // flush in IDLE suppresses the capture as well as the state change
   assign w_capture = (r_state == ST_IDLE) & sif.prod_valid & ~sif.flush;

   z_reg64 #(
      .W (2*DATA_W)
   ) u_z_reg (
      .clk  (clk),
      .clr  (clr),
      .i_en (w_capture),
      .i_d  (sif.prod_in),
      .o_q  (w_z)
   );

   // State and done-pulse registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= ST_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_done_next;
      end
   end

   // Next-state decode and bus/enable muxing
   always_comb begin
      w_next       = r_state;
      w_done_next  = 1'b0;
      w_prod_ready = 1'b0;
      w_bus_valid  = 1'b0;
      w_bus_out    = '0;
      w_lo_en      = 1'b0;
      w_hi_en      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_prod_ready = 1'b1;
            if (w_capture) begin
               w_next = ST_SEND_LO;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_SEND_LO: begin
            w_bus_valid = 1'b1;
            w_bus_out   = w_zlo;
            w_lo_en     = sif.bus_ready & ~sif.flush;
            if (sif.flush) begin
               w_next = ST_IDLE;
            end else if (sif.bus_ready) begin
               w_next = ST_SEND_HI;
            end else begin
               w_next = ST_SEND_LO;
            end
         end
         ST_SEND_HI: begin
            w_bus_valid = 1'b1;
            w_bus_out   = w_zhi;
            w_hi_en     = sif.bus_ready & ~sif.flush;
            if (sif.flush) begin
               w_next = ST_IDLE;
            end else if (sif.bus_ready) begin
               w_next      = ST_IDLE;
               w_done_next = 1'b1;
            end else begin
               w_next = ST_SEND_HI;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign sif.prod_ready = w_prod_ready & ~clr;
   assign sif.bus_valid  = w_bus_valid;
   assign sif.bus_out    = w_bus_out;
   assign sif.lo_en      = w_lo_en;
   assign sif.hi_en      = w_hi_en;
   assign sif.busy       = (r_state != ST_IDLE);
   assign sif.done       = r_done;
   assign sif.fits32     = (w_zhi == {DATA_W{w_zlo[DATA_W-1]}});

endmodule

// File: tb/tb_z_writeback_seq.sv
// Scoreboard bench for z_writeback_seq: stimulus pushes expected LO/HI/done
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_z_writeback_seq;

   typedef struct {
      int          kind;   // 0 = LO write, 1 = HI write, 2 = done
      logic [31:0] data;
      logic        fits;
   } exp_t;

   logic clk;
   logic clr;
   int   total;
   int   bad;
   int   cyc;
   exp_t sb[$];

   z_writeback_seq_if #(.DATA_W(32)) sif ();

   z_writeback_seq #(.DATA_W(32)) dut (
      .clk (clk),
      .clr (clr),
      .sif (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endfunction

   // Reference: a product fits if its signed value lies in the int32 range
   function automatic logic ref_fits(input logic [63:0] p);
      longint sp;
      sp = longint'(p);
      return (sp >= -64'sd2147483648) && (sp <= 64'sd2147483647);
   endfunction

   function automatic void sb_push(input logic [63:0] p);
      exp_t e;
      e.fits = ref_fits(p);
      e.kind = 0; e.data = p[31:0];  sb.push_back(e);
      e.kind = 1; e.data = p[63:32]; sb.push_back(e);
      e.kind = 2; e.data = 32'd0;    sb.push_back(e);
   endfunction

   // Monitor: bus protocol invariants and scoreboard popping
   always @(negedge clk) begin
      if (!clr) begin
         if (sif.lo_en || sif.hi_en || !sif.bus_valid) begin
            chk("en_exclusive", {63'd0, sif.lo_en & sif.hi_en}, 64'd0);
            chk("en_needs_valid", {63'd0, (sif.lo_en | sif.hi_en) & ~sif.bus_valid}, 64'd0);
         end
         if (!sif.bus_valid) chk("bus_out_idle_zero", {32'd0, sif.bus_out}, 64'd0);
         if (sif.lo_en || sif.hi_en || sif.done) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_event", {61'd0, sif.done, sif.hi_en, sif.lo_en}, 64'd0);
            end else begin
               exp_t e;
               int   k;
               e = sb.pop_front();
               k = sif.done ? 2 : (sif.hi_en ? 1 : 0);
               chk("sb_kind", 64'(k), 64'(e.kind));
               if (k != 2) begin
                  chk("sb_word", {32'd0, sif.bus_out}, {32'd0, e.data});
                  chk("sb_fits32", {63'd0, sif.fits32}, {63'd0, e.fits});
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One product with st_lo / st_hi stall cycles of bus backpressure
   task automatic xfer(input logic [63:0] p, input int st_lo, input int st_hi);
      int c0;
      sb_push(p);
      sif.prod_in = p; sif.prod_valid = 1'b1; sif.bus_ready = 1'b0;
      #1;
      chk("idle_prod_ready", {63'd0, sif.prod_ready}, 64'd1);
      tick;
      c0 = cyc;
      for (int i = 0; i < st_lo; i++) begin
         sif.prod_valid = 1'b1; sif.prod_in = {$urandom, $urandom}; sif.bus_ready = 1'b0;
         #1;
         chk("stall_lo_en", {63'd0, sif.lo_en}, 64'd0);
         chk("stall_lo_word", {32'd0, sif.bus_out}, {32'd0, p[31:0]});
         chk("stall_prod_ready", {63'd0, sif.prod_ready}, 64'd0);
         tick;
      end
      sif.bus_ready = 1'b1;
      #1;
      chk("lo_en", {63'd0, sif.lo_en}, 64'd1);
      chk("lo_word", {32'd0, sif.bus_out}, {32'd0, p[31:0]});
      tick;
      for (int i = 0; i < st_hi; i++) begin
         sif.prod_valid = 1'b1; sif.prod_in = {$urandom, $urandom}; sif.bus_ready = 1'b0;
         #1;
         chk("stall_hi_en", {63'd0, sif.hi_en}, 64'd0);
         chk("stall_hi_word", {32'd0, sif.bus_out}, {32'd0, p[63:32]});
         tick;
      end
      sif.bus_ready = 1'b1; sif.prod_valid = 1'b0;
      #1;
      chk("hi_en", {63'd0, sif.hi_en}, 64'd1);
      chk("hi_word", {32'd0, sif.bus_out}, {32'd0, p[63:32]});
      tick;
      chk("done_pulse", {63'd0, sif.done}, 64'd1);
      chk("done_latency", 64'(cyc - c0), 64'(2 + st_lo + st_hi));
      chk("done_prod_ready", {63'd0, sif.prod_ready}, 64'd1);
      chk("done_busy", {63'd0, sif.busy}, 64'd0);
      sif.bus_ready = 1'b0;
      tick;
      chk("done_one_cycle", {63'd0, sif.done}, 64'd0);
   endtask

   initial begin
      logic [63:0] p;
      logic [15:0] r16;
      total = 0; bad = 0; cyc = 0;
      clr = 1'b1;
      sif.prod_valid = 1'b0; sif.prod_in = 64'd0; sif.flush = 1'b0; sif.bus_ready = 1'b0;
      #2;
      chk("rst_busy", {63'd0, sif.busy}, 64'd0);
      chk("rst_bus_valid", {63'd0, sif.bus_valid}, 64'd0);
      chk("rst_bus_out", {32'd0, sif.bus_out}, 64'd0);
      chk("rst_done", {63'd0, sif.done}, 64'd0);
      chk("rst_fits32", {63'd0, sif.fits32}, 64'd1);
      tick; tick;
      clr = 1'b0;
      #1;
      chk("rel_prod_ready", {63'd0, sif.prod_ready}, 64'd1);
      tick;

      xfer(64'h00000000_00000096, 0, 0);
      xfer(64'hFFFFFFFF_FFFFFF6A, 0, 0);
      xfer(64'h00000001_00000000, 0, 0);
      xfer(64'h00000000_7FFFFFFF, 0, 0);
      xfer(64'hFFFFFFFF_80000000, 0, 0);
      xfer(64'h00000000_80000000, 1, 0);
      xfer(64'hFFFFFFFF_7FFFFFFF, 0, 1);
      xfer(64'h12345678_9ABCDEF0, 3, 3);

      // flush together with bus_ready in SEND_HI
      p = 64'hCAFEF00D_0BADBEEF;
      sb_push(p);
      sif.prod_in = p; sif.prod_valid = 1'b1; sif.bus_ready = 1'b1;
      tick;
      sif.prod_valid = 1'b0;
      tick;
      sif.flush = 1'b1;
      #1;
      chk("flush_hi_en", {63'd0, sif.hi_en}, 64'd0);
      tick;
      sif.flush = 1'b0;
      void'(sb.pop_back()); void'(sb.pop_back());
      chk("flush_busy", {63'd0, sif.busy}, 64'd0);
      chk("flush_prod_ready", {63'd0, sif.prod_ready}, 64'd1);
      chk("flush_no_done", {63'd0, sif.done}, 64'd0);
      chk("flush_fits32", {63'd0, sif.fits32}, {63'd0, ref_fits(p)});

      // flush in IDLE with prod_valid: nothing captured
      sif.bus_ready = 1'b0; sif.prod_valid = 1'b1; sif.prod_in = 64'd5; sif.flush = 1'b1;
      tick;
      sif.prod_valid = 1'b0; sif.flush = 1'b0;
      chk("idle_flush_no_capture", {63'd0, sif.busy}, 64'd0);
      chk("idle_flush_z_kept", {63'd0, sif.fits32}, {63'd0, ref_fits(p)});

      // asynchronous clr in SEND_LO
      sif.prod_in = 64'h80000000_00000001; sif.prod_valid = 1'b1;
      tick;
      sif.prod_valid = 1'b0;
      #1;
      chk("pre_clr_valid", {63'd0, sif.bus_valid}, 64'd1);
      clr = 1'b1;
      #1;
      chk("clr_bus_valid", {63'd0, sif.bus_valid}, 64'd0);
      chk("clr_bus_out", {32'd0, sif.bus_out}, 64'd0);
      chk("clr_busy", {63'd0, sif.busy}, 64'd0);
      chk("clr_fits32", {63'd0, sif.fits32}, 64'd1);
      tick;
      clr = 1'b0;
      tick;
      xfer(64'd0, 0, 0);

      for (int n = 0; n < 30; n++) begin
         r16 = 16'($urandom);
         if (n % 2 == 0) p = {{48{r16[15]}}, r16};
         else            p = {$urandom, $urandom};
         xfer(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      tick;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
